reg_dbg_port: RTL and testbench

REG_DBG_PORT -- requirements
Module: reg_dbg_port

---
 rtl/reg_dbg_port_if.sv | 36 +++
 rtl/reg_dbg_port.sv | 147 ++++++++++++++
 tb/tb_reg_dbg_port.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dbg_port_if.sv
// rtl/reg_dbg_port_if.sv - command, load/dump stream and register file signals of reg_dbg_port
// slave is the debug port side; master is the host/register-file side.
interface reg_dbg_port_if #(
  parameter int width = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic [2:0]       out_idx;
  logic [2:0]       rf_rsel;
  logic [width-1:0] rf_rdata;
  logic [2:0]       rf_wsel;
  logic [width-1:0] rf_wdata;
  logic             rf_write;
  logic             rf_err;
  logic             busy;
  logic             err;

  modport slave (
    input  cmd_valid, cmd_op, in_valid, in_data, out_ready, rf_rdata, rf_err,
    output cmd_ready, in_ready, out_valid, out_data, out_idx,
           rf_rsel, rf_wsel, rf_wdata, rf_write, busy, err
  );

  modport master (
    output cmd_valid, cmd_op, in_valid, in_data, out_ready, rf_rdata, rf_err,
    input  cmd_ready, in_ready, out_valid, out_data, out_idx,
           rf_rsel, rf_wsel, rf_wdata, rf_write, busy, err
  );
endinterface

// File: rtl/reg_dbg_port.sv
// rtl/reg_dbg_port.sv - dumps or loads all 8 words of a register file over two streams
// Optional abort input enabled by REG_DBG_PORT_ABORT_EN.
module reg_dbg_port #(
  parameter int width = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef REG_DBG_PORT_ABORT_EN
  input  logic              abort,
`endif
  reg_dbg_port_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DUMP_RD  = 2'd1,
    DUMP_OUT = 2'd2,
    LOAD     = 2'd3
  } state_t;

  state_t           state_q;
  logic [2:0]       idx_q;
  logic [2:0]       rf_rsel_q;
  logic [2:0]       out_idx_q;
  logic [2:0]       rf_wsel_q;
  logic [width-1:0] out_data_q;
  logic [width-1:0] rf_wdata_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             rf_write_q;
  logic             busy_q;
  logic             err_q;
  logic             err_d;
  logic             abort_w;
  logic             abort_act;
  logic             cmd_acc;

`ifdef REG_DBG_PORT_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign abort_act = abort_w && (state_q != IDLE);
  assign cmd_acc   = bus.cmd_valid && (state_q == IDLE);

  // A write still on the bus in the accept cycle belongs to the previous command.
  always_comb begin
    err_d = err_q;
    if (cmd_acc) begin
      err_d = 1'b0;
    end else if (!abort_act && bus.rf_err && ((state_q == DUMP_RD) || rf_write_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      rf_rsel_q   <= 3'd0;
      out_idx_q   <= 3'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      rf_wsel_q   <= 3'd0;
      rf_wdata_q  <= '0;
      rf_write_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rf_write_q <= 1'b0;
      err_q      <= err_d;
      if (abort_act) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b0;
        busy_q      <= 1'b0;
        rf_rsel_q   <= 3'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cmd_acc) begin
              idx_q     <= 3'd0;
              rf_rsel_q <= 3'd0;
              busy_q    <= 1'b1;
              if (bus.cmd_op) begin
                state_q    <= LOAD;
                in_ready_q <= 1'b1;
              end else begin
                state_q <= DUMP_RD;
              end
            end
          end
          DUMP_RD: begin
            out_data_q  <= bus.rf_rdata;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            rf_rsel_q   <= 3'd0;
            state_q     <= DUMP_OUT;
          end
          DUMP_OUT: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              if (idx_q == 3'd7) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                idx_q     <= idx_q + 3'd1;
                rf_rsel_q <= idx_q + 3'd1;
                state_q   <= DUMP_RD;
              end
            end
          end
          LOAD: begin
            if (bus.in_valid) begin
              rf_write_q <= 1'b1;
              rf_wsel_q  <= idx_q;
              rf_wdata_q <= bus.in_data;
              if (idx_q == 3'd7) begin
                state_q    <= IDLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready = !busy_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.rf_rsel   = rf_rsel_q;
  assign bus.rf_wsel   = rf_wsel_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rf_write  = rf_write_q;

endmodule

// File: tb/tb_reg_dbg_port.sv
// tb/tb_reg_dbg_port.sv - randomized self-checking bench for reg_dbg_port
// Abort scenario runs only when REG_DBG_PORT_ABORT_EN is defined.
module tb_reg_dbg_port;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_dbg_port_if #(.width(W)) bus ();
`ifdef REG_DBG_PORT_ABORT_EN
  logic abort;
`endif

  reg_dbg_port #(.width(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef REG_DBG_PORT_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  // External register file plus a log of every write it receives.
  logic [W-1:0] rf_mem [8];
  assign bus.rf_rdata = rf_mem[bus.rf_rsel];

  int cyc = 0;
  int wr_sel_q [$];
  int wr_dat_q [$];
  int wr_cyc_q [$];

  always @(posedge clk) begin
    cyc++;
    if (bus.rf_write) begin
      rf_mem[bus.rf_wsel] <= bus.rf_wdata;
      wr_sel_q.push_back(int'(bus.rf_wsel));
      wr_dat_q.push_back(int'(bus.rf_wdata));
      wr_cyc_q.push_back(cyc);
    end
  end

  logic [W-1:0] model [8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_idx"},   bus.out_idx, 0);
    check({tag, "_in_ready"},  bus.in_ready, 0);
    check({tag, "_rf_write"},  bus.rf_write, 0);
    check({tag, "_rf_wsel"},   bus.rf_wsel, 0);
    check({tag, "_rf_wdata"},  bus.rf_wdata, 0);
    check({tag, "_rf_rsel"},   bus.rf_rsel, 0);
    check({tag, "_err"},       bus.err, 0);
    check({tag, "_busy"},      bus.busy, 0);
  endtask

  // Loads words[0..7]; returns in the first IDLE cycle (last write on the bus).
  task automatic do_load(input logic [W-1:0] words [8], input bit b2b);
    int beat = 0;
    int budget = 0;
    wr_sel_q.delete();
    wr_dat_q.delete();
    wr_cyc_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("load_busy", bus.busy, 1);
    check("load_cmd_ready", bus.cmd_ready, 0);
    check("load_err_clr", bus.err, 0);
    while (beat < 8 && budget < 200) begin
      bus.in_valid  = b2b ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_data   = words[beat];
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 1'b0;
      if (bus.in_valid && bus.in_ready) beat++;
      tick();
      budget++;
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = W'($urandom);
    if (beat < 8) check("load_timeout", beat, 8);
    check("load_done_cmd_ready", bus.cmd_ready, 1);
    check("load_done_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 8; i++) model[i] = words[i];
  endtask

  task automatic check_writes(input logic [W-1:0] words [8], input bit b2b);
    check("wr_count", wr_sel_q.size(), 8);
    for (int i = 0; i < wr_sel_q.size() && i < 8; i++) begin
      check("wr_sel", wr_sel_q[i], i);
      check("wr_data", wr_dat_q[i], int'(words[i]));
      if (b2b && i > 0) check("wr_b2b", wr_cyc_q[i] - wr_cyc_q[i-1], 1);
    end
  endtask

  // mode 0: out_ready held high; 1: random out_ready; 2: stall stall_len cycles on stall_idx.
  task automatic do_dump(input int mode, input int stall_idx, input int stall_len);
    int got = 0;
    int budget = 0;
    int stall = 0;
    int last_cyc = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    check("dump_busy", bus.busy, 1);
    check("dump_err_clr", bus.err, 0);
    while (got < 8 && budget < 400) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 1'b1;
      if (bus.out_valid) begin
        if (mode == 2 && got == stall_idx && stall < stall_len) begin
          bus.out_ready = 1'b0;
          stall++;
          check("stall_idx", bus.out_idx, got);
          check("stall_data", bus.out_data, model[got]);
        end else begin
          bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (bus.out_ready) begin
          check("dump_idx", bus.out_idx, got);
          check("dump_data", bus.out_data, model[got]);
          if (mode == 0 && got > 0) check("dump_rate", cyc - last_cyc, 2);
          last_cyc = cyc;
          got++;
        end
      end else begin
        check("dump_rsel", bus.rf_rsel, got);
        check("dump_cmd_ready", bus.cmd_ready, 0);
        bus.out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      budget++;
    end
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b0;
    if (got < 8) check("dump_timeout", got, 8);
    check("dump_done_cmd_ready", bus.cmd_ready, 1);
    check("dump_done_out_valid", bus.out_valid, 0);
    check("dump_done_rsel", bus.rf_rsel, 0);
  endtask

  logic [W-1:0] w [8];

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.rf_err    = 1'b0;
`ifdef REG_DBG_PORT_ABORT_EN
    abort = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check("reset_cmd_ready", bus.cmd_ready, 1);

    // Fixed pattern load back-to-back, then full-rate dump.
    for (int i = 0; i < 8; i++) w[i] = W'(16'h1111 * (i + 1));
    do_load(w, 1'b1);
    check("load_last_write", bus.rf_write, 1);
    tick();
    check("idle_no_write", bus.rf_write, 0);
    check_writes(w, 1'b1);
    do_dump(0, 0, 0);

    // Back-pressure on index 3.
    do_dump(2, 3, 5);

    // Randomized loads and dumps.
    for (int r = 0; r < 4; r++) begin
      bit b2b;
      b2b = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) w[i] = W'($urandom);
      do_load(w, b2b);
      tick();
      check_writes(w, b2b);
      do_dump(1, 0, 0);
    end

    // Dump accepted in the first IDLE cycle sees the final write to r7.
    for (int i = 0; i < 8; i++) w[i] = W'($urandom);
    w[7] = 16'hBEEF;
    do_load(w, 1'b1);
    do_dump(0, 0, 0);
    check_writes(w, 1'b1);

    // Sticky error from rf_err during a dump.
    bus.rf_err = 1'b1;
    do_dump(0, 0, 0);
    bus.rf_err = 1'b0;
    check("err_set", bus.err, 1);
    repeat (3) tick();
    check("err_sticky", bus.err, 1);
    for (int i = 0; i < 8; i++) w[i] = W'($urandom);
    do_load(w, 1'b1);
    tick();
    check_writes(w, 1'b1);

    // Reset while the 4th beat's write is pending.
    for (int i = 0; i < 8; i++) w[i] = W'($urandom);
    wr_sel_q.delete();
    wr_dat_q.delete();
    wr_cyc_q.delete();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = w[k];
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_reset_pending", bus.rf_write, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    check("mid_reset_cmd_ready", bus.cmd_ready, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mid_reset_wr_count", wr_sel_q.size(), 3);
    for (int i = 0; i < 3; i++) model[i] = w[i];
    do_dump(1, 0, 0);

`ifdef REG_DBG_PORT_ABORT_EN
    begin
      int budget = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 1'b0;
      tick();
      bus.cmd_valid = 1'b0;
      while (!(bus.out_valid && bus.out_idx == 3'd2) && budget < 50) begin
        bus.out_ready = 1'b1;
        tick();
        budget++;
      end
      check("abort_reach_idx2", bus.out_idx, 2);
      bus.out_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_cmd_ready", bus.cmd_ready, 1);
      check("abort_busy", bus.busy, 0);
      check("abort_err", bus.err, 0);
      do_dump(0, 0, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
